uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b010;
    localparam logic [2:0] ST_PARITY = 3'b011;
    localparam logic [2:0] ST_STOP   = 3'b100;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK   = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterizable reset value so an idle-high line resets to 1.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q shift as a true two-stage pipeline.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8 data bits LSB first, optional parity,
// configurable stop length, with framing/parity/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int SB_TICKS   = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       b_tick,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] d_out,
    output logic       rx_done,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int             SBW     = (SB_TICKS > 2) ? $clog2(SB_TICKS) : 1;
    localparam logic [SBW-1:0] SB_LAST = SBW'(SB_TICKS - 1);

    logic           rx_s;
    logic [2:0]     state, state_nxt;
    logic [3:0]     s_cnt, s_cnt_nxt;
    logic [2:0]     n_cnt, n_cnt_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic [SBW-1:0] sb_cnt, sb_cnt_nxt;
    logic           par_err_q, par_err_nxt;
    logic           complete;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rx),
        .q      (rx_s)
    );

    // NOTE: the shift register is plain flops, not a memory, so it is reset with the rest.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shreg     <= '0;
            sb_cnt    <= '0;
            par_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_cnt     <= s_cnt_nxt;
            n_cnt     <= n_cnt_nxt;
            shreg     <= shreg_nxt;
            sb_cnt    <= sb_cnt_nxt;
            par_err_q <= par_err_nxt;
        end
    end

    // NOTE: every signal gets a hold default up front so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        s_cnt_nxt   = s_cnt;
        n_cnt_nxt   = n_cnt;
        shreg_nxt   = shreg;
        par_err_nxt = par_err_q;
        sb_cnt_nxt  = (state == ST_STOP) ? sb_cnt : '0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    s_cnt_nxt = '0;
                end
            end
            ST_START: begin
                if (b_tick) begin
                    if (s_cnt == MID_TICK) begin
                        // A high line at mid start bit was a glitch, not a frame.
                        state_nxt = rx_s ? ST_IDLE : ST_DATA;
                        s_cnt_nxt = '0;
                        n_cnt_nxt = '0;
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (b_tick) begin
                    if (s_cnt == LAST_TICK) begin
                        shreg_nxt = {rx_s, shreg[7:1]};
                        s_cnt_nxt = '0;
                        n_cnt_nxt = n_cnt + 3'd1;
                        if (n_cnt == 3'd7)
                            state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (b_tick) begin
                    if (s_cnt == LAST_TICK) begin
                        par_err_nxt = PARITY_EN && ((^shreg ^ rx_s) != PARITY_ODD);
                        state_nxt   = ST_STOP;
                        s_cnt_nxt   = '0;
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (b_tick) begin
                    if (sb_cnt == SB_LAST)
                        state_nxt = ST_IDLE;
                    else
                        sb_cnt_nxt = sb_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        complete = (state == ST_STOP) && b_tick && (sb_cnt == SB_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_out      <= '0;
            rx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done    <= complete;
            frame_err  <= complete && !rx_s;
            parity_err <= complete && PARITY_EN && par_err_q;
            overrun    <= complete && rx_valid && !rd_ack;
            if (complete) begin
                d_out    <= shreg;
                rx_valid <= 1'b1;
            end else if (rd_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a no-parity and an even-parity instance share
// the clock and a b_tick pulse every 4 clk.
module tb_uart_rx;

    typedef struct {
        int         inst;
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
        bit         stop_ok;
        logic [7:0] exp_d;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       b_tick = 1'b0;
    logic       rx [2];
    logic       rd_ack [2];
    logic [7:0] d_out [2];
    logic       rx_done [2];
    logic       rx_valid [2];
    logic       frame_err [2];
    logic       parity_err [2];
    logic       overrun [2];

    int done_c [2] = '{0, 0};
    int ferr_c [2] = '{0, 0};
    int perr_c [2] = '{0, 0};
    int ovr_c  [2] = '{0, 0};
    int lone_c [2] = '{0, 0};
    int base_done, base_ferr, base_perr, base_ovr, base_lone;
    int checks = 0;
    int errors = 0;
    int tick_phase = 0;
    vec_t vecs [5];

    uart_rx dut0 (
        .clk(clk), .resetn(resetn), .b_tick(b_tick), .rx(rx[0]), .rd_ack(rd_ack[0]),
        .d_out(d_out[0]), .rx_done(rx_done[0]), .rx_valid(rx_valid[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0])
    );

    uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SB_TICKS(16)) dut1 (
        .clk(clk), .resetn(resetn), .b_tick(b_tick), .rx(rx[1]), .rd_ack(rd_ack[1]),
        .d_out(d_out[1]), .rx_done(rx_done[1]), .rx_valid(rx_valid[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1])
    );

    always #5 clk = ~clk;

    // b_tick changes on the falling edge so it is stable at every rising edge.
    always @(negedge clk) begin
        tick_phase = (tick_phase + 1) % 4;
        b_tick = (tick_phase == 3);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_done[i]) done_c[i]++;
            if (frame_err[i]) ferr_c[i]++;
            if (parity_err[i]) perr_c[i]++;
            if (overrun[i]) ovr_c[i]++;
            if ((frame_err[i] || parity_err[i] || overrun[i]) && !rx_done[i]) lone_c[i]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; ) begin
            @(posedge clk);
            if (b_tick) k++;
        end
    endtask

    task automatic send_bit(input int i, input logic v, input int n);
        #1 rx[i] = v;
        wait_ticks(n);
    endtask

    task automatic send_head(input int i, input logic [7:0] data);
        send_bit(i, 1'b0, 16);
        for (int b = 0; b < 8; b++) send_bit(i, data[b], 16);
    endtask

    task automatic send_frame(input int i, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input bit stop_ok, input bit idle);
        send_head(i, data);
        if (par_en) send_bit(i, par_bit, 16);
        if (stop_ok) begin
            send_bit(i, 1'b1, 16);
        end else begin
            // Release the line early so the restart after the bad stop is rejected.
            send_bit(i, 1'b0, 12);
            send_bit(i, 1'b1, 4);
        end
        if (idle) send_bit(i, 1'b1, 16);
    endtask

    task automatic ack(input int i);
        @(posedge clk);
        #1 rd_ack[i] = 1'b1;
        @(posedge clk);
        #1 rd_ack[i] = 1'b0;
    endtask

    task automatic snap(input int i);
        base_done = done_c[i];
        base_ferr = ferr_c[i];
        base_perr = perr_c[i];
        base_ovr  = ovr_c[i];
        base_lone = lone_c[i];
    endtask

    task automatic expect_counts(input string tag, input int i, input int done,
                                 input int ferr, input int perr, input int ovr);
        check($sformatf("%s rx_done count", tag), done_c[i] - base_done, done);
        check($sformatf("%s frame_err count", tag), ferr_c[i] - base_ferr, ferr);
        check($sformatf("%s parity_err count", tag), perr_c[i] - base_perr, perr);
        check($sformatf("%s overrun count", tag), ovr_c[i] - base_ovr, ovr);
        check($sformatf("%s pulse without rx_done", tag), lone_c[i] - base_lone, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s d_out[%0d]", tag, i), d_out[i], 8'h00);
            check($sformatf("%s rx_valid[%0d]", tag, i), rx_valid[i], 1'b0);
            check($sformatf("%s pulses[%0d]", tag, i),
                  {rx_done[i], frame_err[i], parity_err[i], overrun[i]}, 4'b0000);
        end
    endtask

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1, 0};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 0, 1};
        vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 0, 0};
        vecs[4] = '{1, 8'hC0, 1'b1, 1'b0, 1'b1, 8'hC0, 0, 0};

        rx[0] = 1'b1; rx[1] = 1'b1;
        rd_ack[0] = 1'b0; rd_ack[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs("reset");
        resetn = 1'b1;
        send_bit(0, 1'b1, 8);

        for (int v = 0; v < 5; v++) begin
            snap(vecs[v].inst);
            send_frame(vecs[v].inst, vecs[v].data, vecs[v].par_en, vecs[v].par_bit,
                       vecs[v].stop_ok, 1'b1);
            expect_counts($sformatf("vec%0d", v), vecs[v].inst, 1, vecs[v].exp_ferr,
                          vecs[v].exp_perr, 0);
            check($sformatf("vec%0d d_out", v), d_out[vecs[v].inst], vecs[v].exp_d);
            check($sformatf("vec%0d rx_valid", v), rx_valid[vecs[v].inst], 1'b1);
            ack(vecs[v].inst);
            check($sformatf("vec%0d rx_valid after rd_ack", v), rx_valid[vecs[v].inst], 1'b0);
        end

        // rd_ack with nothing pending must not disturb anything.
        ack(0);
        check("idle rd_ack rx_valid", rx_valid[0], 1'b0);
        check("idle rd_ack d_out", d_out[0], 8'hA5 ^ 8'hA5 ^ 8'h55);

        // Start-bit glitch of 5 ticks, then a valid frame.
        snap(0);
        send_bit(0, 1'b0, 5);
        send_bit(0, 1'b1, 32);
        expect_counts("glitch", 0, 0, 0, 0, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_counts("after glitch", 0, 1, 0, 0, 0);
        check("after glitch d_out", d_out[0], 8'h3C);
        ack(0);

        // Back-to-back frames with no read in between.
        snap(0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_counts("b2b overrun", 0, 2, 0, 0, 1);
        check("b2b overrun d_out", d_out[0], 8'h22);
        check("b2b overrun rx_valid", rx_valid[0], 1'b1);
        ack(0);

        // Same, but the consumer reads exactly on the completion cycle of 0x22.
        snap(0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_head(0, 8'h22);
        send_bit(0, 1'b1, 7);
        repeat (3) @(posedge clk);
        #1 rd_ack[0] = 1'b1;
        @(posedge clk);
        #1 rd_ack[0] = 1'b0;
        wait_ticks(8);
        send_bit(0, 1'b1, 16);
        expect_counts("b2b with ack", 0, 2, 0, 0, 0);
        check("b2b with ack d_out", d_out[0], 8'h22);
        check("b2b with ack rx_valid", rx_valid[0], 1'b1);

        // Reset during data bit 4 of 0xFF; rx_valid is still set going in.
        snap(0);
        send_bit(0, 1'b0, 16);
        send_bit(0, 1'b1, 64 + 8);
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("mid-frame reset");
        resetn = 1'b1;
        send_bit(0, 1'b1, 8 + 48 + 16 + 32);
        expect_counts("aborted frame", 0, 0, 0, 0, 0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_counts("after reset", 0, 1, 0, 0, 0);
        check("after reset d_out", d_out[0], 8'h81);
        check("after reset rx_valid", rx_valid[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
